key_schedule_ctrl: RTL

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/key_schedule_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
//   Expands an M-word Simon master key into the full T-word round-key schedule,
//   writing one round key per clock after a one-cycle load of the master key.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   request expansion of key_in (accepted only when idle)
//   key_in      in   N*M master key, word j at key_in[(j+1)*N-1 -: N]
//   busy        out  expansion in progress
//   done        out  one-cycle pulse after the last round key is written
//   keys_valid  out  store holds a complete schedule
//   rd_addr     in   round-key read index
//   rd_data     out  ks[rd_addr], zero when rd_addr >= T
module key_schedule_ctrl #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*M-1:0] key_in,
    output logic           busy,
    output logic           done,
    output logic           keys_valid,
    input  logic [7:0]     rd_addr,
    output logic [N-1:0]   rd_data
);

    // Simon z sequences; the leftmost character (bit 61) is z[0].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic int unsigned calc_rounds(input int unsigned n, input int unsigned m);
        int unsigned t;
        case (n)
            16:      t = 32;
            24:      t = 36;
            32:      t = (m == 3) ? 42 : 44;
            48:      t = (m == 2) ? 52 : 54;
            64:      t = (m == 2) ? 68 : ((m == 3) ? 69 : 72);
            default: t = 32;
        endcase
        return t;
    endfunction

    function automatic logic [61:0] z_select(input int unsigned n, input int unsigned m);
        logic [61:0] z;
        case (n)
            16:      z = Z0;
            24:      z = (m == 3) ? Z0 : Z1;
            32:      z = (m == 3) ? Z2 : Z3;
            48:      z = (m == 2) ? Z2 : Z3;
            64:      z = (m == 2) ? Z2 : ((m == 3) ? Z3 : Z4);
            default: z = Z0;
        endcase
        return z;
    endfunction

    localparam int unsigned T      = calc_rounds(N, M);
    localparam logic [61:0] Z_SEQ  = z_select(N, M);
    // Position of ks[rnd-3] inside the history word; only meaningful for M=4.
    localparam int unsigned K3_POS = (M == 4) ? 1 : 0;
    // ~k ^ 3 folded into a single constant: all ones except the two LSBs.
    localparam logic [N-1:0] C_CONST = {{(N-2){1'b1}}, 2'b00};

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } state_t;

    state_t         r_state;
    logic [7:0]     r_rnd;
    logic           r_busy;
    logic           r_done;
    logic           r_valid;
    // Round-key store, word i at [i*N +: N]; deliberately not reset.
    logic [T*N-1:0] r_ks;

    logic [T*N-1:0] w_ks_d;
    logic [N*M-1:0] w_hist;
    logic [N-1:0]   w_next_key;
    logic           w_load;
    logic           w_step;

    // One Simon key-expansion step. hist = {ks[rnd-1], ..., ks[rnd-M]}.
    function automatic logic [N-1:0] key_expansion(input logic [N*M-1:0] hist,
                                                   input logic [7:0]     rnd);
        logic [N-1:0] k_last;
        logic [N-1:0] k_first;
        logic [N-1:0] tmp;
        logic [7:0]   zidx;
        k_last  = hist[N*M-1 -: N];
        k_first = hist[N-1:0];
        tmp     = {k_last[2:0], k_last[N-1:3]};
        if (M == 4) begin
            tmp = tmp ^ hist[K3_POS*N +: N];
        end
        tmp  = tmp ^ {tmp[0], tmp[N-1:1]};
        zidx = rnd - 8'(M);
        if (zidx >= 8'd62) begin
            zidx = zidx - 8'd62;
        end
        return k_first ^ C_CONST ^ tmp ^ {{(N-1){1'b0}}, Z_SEQ[6'd61 - zidx[5:0]]};
    endfunction

    assign w_load = (r_state == S_IDLE) && start;
    assign w_step = (r_state == S_EXPAND);

    always_comb begin : hist_gather
        logic [7:0] idx;
        idx    = '0;
        w_hist = '0;
        for (int j = 0; j < int'(M); j++) begin
            idx = r_rnd - 8'(j + 1);
            // Guard keeps idle-state reads (rnd < M) inside the store.
            if (idx < 8'(T)) begin
                w_hist[(M-1-j)*N +: N] = r_ks[idx*N +: N];
            end
        end
    end

    always_comb begin : key_expansion_dp
        w_next_key = key_expansion(w_hist, r_rnd);
    end

    always_comb begin : ks_next
        w_ks_d = r_ks;
        if (w_load) begin
            // Key words land at ks[0..M-1]; the packing is identical to key_in.
            w_ks_d[N*M-1:0] = key_in;
        end else if (w_step) begin
            w_ks_d[r_rnd*N +: N] = w_next_key;
        end
    end

    always_ff @(posedge clk) begin : ks_store
        r_ks <= w_ks_d;
    end

    always_ff @(posedge clk or posedge rst) begin : ctrl_fsm
        if (rst) begin
            r_state <= S_IDLE;
            r_rnd   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_EXPAND;
                        r_rnd   <= 8'(M);
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    r_rnd <= r_rnd + 8'd1;
                    if (r_rnd == 8'(T - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_valid;
    assign rd_data    = (rd_addr < 8'(T)) ? r_ks[rd_addr*N +: N] : '0;

endmodule
